// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - word-wide memory bus between the access unit and memory
//
// Signals:
//   mem_req   request valid, held until mem_ack is sampled
//   mem_we    write strobe, only high together with mem_req
//   mem_addr  word-aligned byte address (bits [1:0] are always 00)
//   mem_be    per-lane byte enables
//   mem_wdata lane-positioned store data
//   mem_rdata read word returned by memory
//   mem_ack   completion, only meaningful while mem_req=1
// Modports: master (access unit side), slave (memory side).
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/halfword/word load-store unit with core stall handshake
//
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   MemW, MemRd store / load request from the decoder (both high = store)
//   be          access size: 0001 byte, 0011 halfword, anything else word
//   SignExt     sign-extend byte/halfword loads
//   Addr        byte address, WriteData right-justified store data
//   ReadData    registered, aligned and extended load result
//   Stall       core hold, Done one-cycle completion pulse
//   Fault       misalignment pulse (only with MEM_ALIGN_TRAP_EN)
//   mem         memory bus, master side
// Optional feature: define MEM_ALIGN_TRAP_EN to trap misaligned halfword/word
// accesses instead of silently dropping the low address bits.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemW,
    input  logic        MemRd,
    input  logic [3:0]  be,
    input  logic        SignExt,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
`ifdef MEM_ALIGN_TRAP_EN
    output logic        Fault,
`endif
    mem_access_unit_if.master mem
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]  state;
    logic [1:0]  size_in;
    logic [1:0]  off_in;
    logic [3:0]  mask_in;
    logic        start;

    logic        store_q;
    logic        sext_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;

    logic [31:0] rdata_shifted;
    logic [31:0] load_val;

    // Decode size from be; unlisted encodings fall back to a word access.
    always_comb begin
        size_in = SZ_WORD;
        mask_in = 4'b1111;
        off_in  = 2'b00;
        case (be)
            4'b0001: begin
                size_in = SZ_BYTE;
                mask_in = 4'b0001;
                off_in  = Addr[1:0];
            end
            4'b0011: begin
                size_in = SZ_HALF;
                mask_in = 4'b0011;
                off_in  = {Addr[1], 1'b0};
            end
            default: begin
                size_in = SZ_WORD;
                mask_in = 4'b1111;
                off_in  = 2'b00;
            end
        endcase
    end

    assign start = (state == ST_IDLE) && (MemW || MemRd);

`ifdef MEM_ALIGN_TRAP_EN
    logic misalign;
    logic fault_q;

    assign misalign = ((size_in == SZ_HALF) && Addr[0]) ||
                      ((size_in == SZ_WORD) && (Addr[1:0] != 2'b00));
`endif

    // Load alignment: bring the addressed lane down to bit 0, then extend.
    assign rdata_shifted = mem.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_val = rdata_shifted;
        case (size_q)
            SZ_BYTE: load_val = {{24{sext_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
            SZ_HALF: load_val = {{16{sext_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_val = rdata_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            store_q       <= 1'b0;
            sext_q        <= 1'b0;
            size_q        <= SZ_BYTE;
            off_q         <= 2'b00;
            mem.mem_addr  <= 32'd0;
            mem.mem_be    <= 4'd0;
            mem.mem_wdata <= 32'd0;
            ReadData      <= 32'd0;
`ifdef MEM_ALIGN_TRAP_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Store wins when both request lines are high.
                        store_q       <= MemW;
                        sext_q        <= SignExt;
                        size_q        <= size_in;
                        off_q         <= off_in;
                        mem.mem_addr  <= {Addr[31:2], 2'b00};
                        mem.mem_be    <= mask_in << off_in;
                        mem.mem_wdata <= WriteData << {off_in, 3'b000};
`ifdef MEM_ALIGN_TRAP_EN
                        fault_q       <= misalign;
                        state         <= misalign ? ST_DONE : ST_REQ;
`else
                        state         <= ST_REQ;
`endif
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ack) begin
                        if (!store_q) begin
                            ReadData <= load_val;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Requests seen here are ignored; the core re-presents in IDLE.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req = (state == ST_REQ);
    assign mem.mem_we  = (state == ST_REQ) && store_q;
    assign Done        = (state == ST_DONE);
    // Gated by reset so the hold drops in the reset cycle itself.
    assign Stall       = !reset && (start || (state == ST_REQ));

`ifdef MEM_ALIGN_TRAP_EN
    assign Fault = (state == ST_DONE) && fault_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemW, MemRd, SignExt;
    logic [3:0]  be;
    logic [31:0] Addr, WriteData;
    logic [31:0] ReadData;
    logic        Stall, Done;
`ifdef MEM_ALIGN_TRAP_EN
    logic        Fault;
`endif

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk       (clk),
        .reset     (reset),
        .MemW      (MemW),
        .MemRd     (MemRd),
        .be        (be),
        .SignExt   (SignExt),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .Done      (Done),
`ifdef MEM_ALIGN_TRAP_EN
        .Fault     (Fault),
`endif
        .mem       (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_rd;
    bit          in_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int size_of(input logic [3:0] b);
        if (b == 4'b0001) return 1;
        if (b == 4'b0011) return 2;
        return 4;
    endfunction

    // One complete access starting at a negedge in IDLE (or DONE when in_done).
    task automatic do_access(input bit w, input bit r, input logic [3:0] b,
                             input logic [31:0] a, input logic [31:0] wd,
                             input bit se, input int dly, input logic [31:0] rdat);
        int          sz, off;
        logic [3:0]  e_be;
        logic [31:0] e_wd, lane_mask;
        longint      v;
        sz  = size_of(b);
        off = (sz == 1) ? int'(a % 4) : (sz == 2) ? int'(a % 4) & 2 : 0;
        e_be = 4'(((1 << sz) - 1) << off);
        e_wd = 32'd0;
        lane_mask = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + sz) begin
                e_wd[8*i +: 8]      = wd[8*(i-off) +: 8];
                lane_mask[8*i +: 8] = 8'hFF;
            end
        end
        MemW = w; MemRd = r; be = b; Addr = a; WriteData = wd; SignExt = se;
        bus.mem_ack = 1'b0;
        if (in_done) begin
            #1 check("stall_in_done", Stall, 0);
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("stall_idle", Stall, 1);
        check("done_idle", Done, 0);
        check("req_idle", bus.mem_req, 0);
        @(posedge clk);
        for (int c = 0; c <= dly; c++) begin
            @(negedge clk);
            check("req_hi", bus.mem_req, 1);
            check("we", bus.mem_we, w);
            check("addr", bus.mem_addr, {a[31:2], 2'b00});
            check("be", bus.mem_be, e_be);
            check("wdata", bus.mem_wdata & lane_mask, e_wd);
            check("stall_req", Stall, 1);
            check("rd_hold", ReadData, exp_rd);
            bus.mem_ack   = (c == dly);
            bus.mem_rdata = (c == dly) ? rdat : $urandom;
            @(posedge clk);
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        if (!w) begin
            v = longint'((rdat >> (8 * off))) & ((64'd1 << (8 * sz)) - 1);
            if (se && sz < 4 && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
            exp_rd = v[31:0];
        end
        check("done_pulse", Done, 1);
        check("stall_done", Stall, 0);
        check("req_done", bus.mem_req, 0);
        check("we_done", bus.mem_we, 0);
        check("rd_done", ReadData, exp_rd);
        in_done = 1'b1;
    endtask

    task automatic idle_cycle();
        MemW = 1'b0; MemRd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("done_low", Done, 0);
        check("stall_low", Stall, 0);
        check("rd_idle", ReadData, exp_rd);
        in_done = 1'b0;
    endtask

    initial begin
        int          sz;
        logic [3:0]  rb;
        logic [31:0] ra;
        bit          rw, rr;
        reset = 1'b1; MemW = 1'b0; MemRd = 1'b0; be = 4'b0; SignExt = 1'b0;
        Addr = 32'd0; WriteData = 32'd0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
        exp_rd = 32'd0; in_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", Stall, 0);
        check("rst_done", Done, 0);
        check("rst_req", bus.mem_req, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_be", bus.mem_be, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_rd", ReadData, 0);
        reset = 1'b0;

        // Byte load, sign-extended, ack after one cycle.
        do_access(0, 1, 4'b0001, 32'h103, 32'h0, 1, 1, 32'h80AABBCC);
        check("byte_load_val", ReadData, 32'hFFFFFF80);
        idle_cycle();

        // Halfword store at 0x22; ReadData must not change.
        do_access(1, 0, 4'b0011, 32'h22, 32'h1234ABCD, 0, 2, $urandom);
        check("half_store_rd", ReadData, 32'hFFFFFF80);
        idle_cycle();

        // Word load with a late ack.
        do_access(0, 1, 4'b1111, 32'h400, 32'h0, 0, 5, 32'hDEADBEEF);
        check("word_load_val", ReadData, 32'hDEADBEEF);
        idle_cycle();

        // Back-to-back loads; second is presented during DONE.
        do_access(0, 1, 4'b0001, 32'h201, 32'h0, 0, 0, 32'h0000F700);
        do_access(0, 1, 4'b0011, 32'h200, 32'h0, 0, 0, 32'h55558001);
        check("b2b_half_val", ReadData, 32'h00008001);
        idle_cycle();

        // Both request lines high -> store; unlisted be -> word.
        do_access(1, 1, 4'b0101, 32'h10, 32'hCAFEF00D, 0, 1, 32'h11111111);
        idle_cycle();

        // Reset in the middle of REQ, then a late ack.
        MemRd = 1'b1; be = 4'b1111; Addr = 32'h40; SignExt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_req", bus.mem_req, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; MemRd = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
        #1;
        exp_rd = 32'd0;
        check("rst_mid_req_lo", bus.mem_req, 0);
        check("rst_mid_done", Done, 0);
        check("rst_mid_stall", Stall, 0);
        check("rst_mid_be", bus.mem_be, 0);
        check("rst_mid_addr", bus.mem_addr, 0);
        check("rst_mid_rd", ReadData, 0);
        @(posedge clk);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("late_ack_done", Done, 0);
        check("late_ack_req", bus.mem_req, 0);
        check("late_ack_rd", ReadData, 0);
        in_done = 1'b0;

`ifdef MEM_ALIGN_TRAP_EN
        MemRd = 1'b1; be = 4'b1111; Addr = 32'h101;
        #1 check("trap_stall", Stall, 1);
        @(posedge clk);
        @(negedge clk);
        check("trap_req", bus.mem_req, 0);
        check("trap_done", Done, 1);
        check("trap_fault", Fault, 1);
        check("trap_rd", ReadData, exp_rd);
        in_done = 1'b1;
        idle_cycle();
        check("trap_fault_lo", Fault, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            case ($urandom % 4)
                0: rb = 4'b0001;
                1: rb = 4'b0011;
                2: rb = 4'b1111;
                default: rb = 4'($urandom);
            endcase
            ra = $urandom;
`ifdef MEM_ALIGN_TRAP_EN
            sz = size_of(rb);
            ra = ra & ~32'(sz - 1);
`else
            sz = 0;
`endif
            rw = ($urandom % 2) == 1;
            rr = !rw || (($urandom % 2) == 1);
            do_access(rw, rr, rb, ra, $urandom, ($urandom % 2) == 1,
                      int'($urandom % 4), $urandom);
            if ($urandom % 2) idle_cycle();
        end
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
